// File: rtl/loader_pkg.sv
// Shared state encoding and frame constants for the program loader.
package loader_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CSUM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_HDR   = S_HDR,
        ST_DATA  = S_DATA,
        ST_CSUM  = S_CSUM,
        ST_DONE  = S_DONE,
        ST_ERROR = S_ERROR
    } state_e;

    localparam int HEADER_BYTES = 2;
    localparam int CSUM_WIDTH   = 8;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: first byte of a word lands in bits 7:0.
module byte_packer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  valid_i,
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_done_o
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] LAST = CW'(BPW - 1);

    logic [CW-1:0] cnt_q;

    assign word_done_o = valid_i && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q <= '0;
        end else if (valid_i) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    generate
        if (BPW > 1) begin : g_shift
            // Word presented combinationally so the final byte needs no extra cycle.
            logic [DATA_WIDTH-9:0] shift_q;

            assign word_o = {byte_i, shift_q};

            always_ff @(posedge clk) begin
                if (reset || clear_i) begin
                    shift_q <= '0;
                end else if (valid_i) begin
                    shift_q <= word_o[DATA_WIDTH-1:8];
                end
            end
        end else begin : g_single
            assign word_o = byte_i;
        end
    endgenerate

endmodule

// File: rtl/program_loader.sv
// Framed byte stream to instruction-memory writer; holds the core while loading.
// Optional trailer checksum enabled by defining LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start_i after reset
// HDR   | collecting 2-byte little-endian word count
// DATA  | packing bytes into words and writing them
// CSUM  | waiting for trailer byte (checksum build only)
// DONE  | load completed, core released
// ERROR | oversize count or bad checksum, core held
module program_loader
    import loader_pkg::*;
#(
    parameter int MEMORY_DEPTH = 64,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_i,
    input  logic [7:0]                      rx_data_i,
    input  logic                            rx_valid_i,
    output logic                            rx_ready_o,
    output logic                            we_o,
    output logic [$clog2(MEMORY_DEPTH)-1:0] waddr_o,
    output logic [DATA_WIDTH-1:0]           wdata_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o,
    output logic                            core_hold_o
);

    localparam int AW = $clog2(MEMORY_DEPTH);
    localparam logic [16:0] DEPTH_W = 17'(MEMORY_DEPTH);

`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    state_e                state_q, state_d;
    logic                  hdr_hi_q, hdr_hi_d;
    logic [7:0]            hdr_lo_q, hdr_lo_d;
    logic [15:0]           words_left_q, words_left_d;
    logic [AW-1:0]         waddr_q, waddr_d;
    logic                  wrote_any_q, wrote_any_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [CSUM_WIDTH-1:0] csum_q, csum_d;

    logic                  accept;
    logic                  start_ok;
    logic                  pk_valid;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] pk_word;
    logic [15:0]           hdr_n;
    logic [CSUM_WIDTH-1:0] csum_next;
    state_e                end_state;

    assign rx_ready_o  = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign busy_o      = rx_ready_o;
    assign core_hold_o = busy_o || (state_q == ST_ERROR);
    assign done_o      = (state_q == ST_DONE);
    assign error_o     = (state_q == ST_ERROR);
    assign we_o        = we_q;
    assign waddr_o     = waddr_q;
    assign wdata_o     = wdata_q;

    assign accept    = rx_valid_i && rx_ready_o;
    assign start_ok  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
    assign pk_valid  = accept && (state_q == ST_DATA);
    assign hdr_n     = {rx_data_i, hdr_lo_q};
    assign csum_next = csum_q + rx_data_i;
    assign end_state = CSUM_EN ? ST_CSUM : ST_DONE;

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (start_ok),
        .valid_i     (pk_valid),
        .byte_i      (rx_data_i),
        .word_o      (pk_word),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d      = state_q;
        hdr_hi_d     = hdr_hi_q;
        hdr_lo_d     = hdr_lo_q;
        words_left_d = words_left_q;
        waddr_d      = waddr_q;
        wrote_any_d  = wrote_any_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        csum_d       = accept ? csum_next : csum_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    state_d      = ST_HDR;
                    hdr_hi_d     = 1'b0;
                    words_left_d = '0;
                    waddr_d      = '0;
                    wrote_any_d  = 1'b0;
                    csum_d       = '0;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    if (!hdr_hi_q) begin
                        hdr_lo_d = rx_data_i;
                        hdr_hi_d = 1'b1;
                    end else if (hdr_n == 16'd0) begin
                        state_d = end_state;
                    end else if ({1'b0, hdr_n} > DEPTH_W) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d      = ST_DATA;
                        words_left_d = hdr_n;
                    end
                end
            end
            ST_DATA: begin
                if (word_done) begin
                    // First write goes to 0; later writes advance, so the last address is N-1.
                    we_d         = 1'b1;
                    wdata_d      = pk_word;
                    waddr_d      = wrote_any_q ? waddr_q + 1'b1 : '0;
                    wrote_any_d  = 1'b1;
                    words_left_d = words_left_q - 16'd1;
                    if (words_left_q == 16'd1) begin
                        state_d = end_state;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (csum_next == '0) ? ST_DONE : ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hdr_hi_q     <= 1'b0;
            hdr_lo_q     <= '0;
            words_left_q <= '0;
            waddr_q      <= '0;
            wrote_any_q  <= 1'b0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            csum_q       <= '0;
        end else begin
            state_q      <= state_d;
            hdr_hi_q     <= hdr_hi_d;
            hdr_lo_q     <= hdr_lo_d;
            words_left_q <= words_left_d;
            waddr_q      <= waddr_d;
            wrote_any_q  <= wrote_any_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            csum_q       <= csum_d;
        end
    end

endmodule
